alu_arbiter: RTL and testbench

Shares the single 8-bit ALU datapath (ADD through NEG, 4-bit select, one-cycle registered result on `do`) among up to four requesters. Each requester presents an opcode and two operands under a level request. The block grants one requester at a time, drives the ALU's A/B/select/do inputs, captures the registered result and returns it with a one-cycle done pulse. It sits between the front-end command sources and the ALU and is the only driver of the ALU inputs.

---
 rtl/alu_pkg.sv | 34 +++
 rtl/alu_arbiter_rr_pick.sv | 26 ++
 rtl/alu_arbiter.sv | 166 ++++++++++++++++
 tb/tb_alu_arbiter.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode constants, arbiter FSM state type and opcode classification
// for the ALU arbiter slice.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_ADC  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_SBC  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_NOT  = 4'h7;
  localparam logic [3:0] OP_SHL  = 4'h8;
  localparam logic [3:0] OP_SHR  = 4'h9;
  localparam logic [3:0] OP_ROL  = 4'hA;
  localparam logic [3:0] OP_CMP  = 4'hB;
  localparam logic [3:0] OP_NEG  = 4'hC;
  localparam logic [3:0] OP_STO  = 4'hD;
  localparam logic [3:0] OP_SWP  = 4'hE;
  localparam logic [3:0] OP_LOAD = 4'hF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  // STO/SWP/LOAD never produce a Y, so the arbiter rejects them without using the ALU.
  function automatic logic op_no_result(input logic [3:0] sel);
    return (sel == OP_STO) || (sel == OP_SWP) || (sel == OP_LOAD);
  endfunction

endpackage

// File: rtl/alu_arbiter_rr_pick.sv
// Combinational round-robin pick: one-hot grant to the first requester at or
// after the pointer, wrapping around NUM_REQ.
module rr_pick #(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         ptr,
  output logic [NUM_REQ-1:0] grant
);

  logic found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
        if (!found && req[j] && (j == (32'(ptr) + off) % NUM_REQ)) begin
          grant[j] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates up to four requesters onto the single shared ALU datapath.
// Define ALU_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [4*NUM_REQ-1:0]   req_select,
  input  logic [8*NUM_REQ-1:0]   req_a,
  input  logic [8*NUM_REQ-1:0]   req_b,
  output logic [NUM_REQ-1:0]     ack,
  output logic [NUM_REQ-1:0]     done,
  output logic                   err,
  output logic [7:0]             result,
  output logic [7:0]             alu_a,
  output logic [7:0]             alu_b,
  output logic [3:0]             alu_select,
  output logic                   alu_do,
  input  logic [7:0]             alu_y,
  output logic                   busy
);

  arb_state_t         state_q, state_d;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] win_q, win_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic               err_q, err_d;
  logic [7:0]         result_q, result_d;
  logic [7:0]         alu_a_q, alu_a_d;
  logic [7:0]         alu_b_q, alu_b_d;
  logic [3:0]         alu_sel_q, alu_sel_d;
  logic               alu_do_q, alu_do_d;
  logic [3:0]         g_sel;
  logic [7:0]         g_a, g_b;

`ifdef ALU_ARB_FIXED_PRIO_EN
  always_comb begin
    grant = '0;
    for (int unsigned i = NUM_REQ; i > 0; i--) begin
      if (req[i-1]) begin
        grant      = '0;
        grant[i-1] = 1'b1;
      end
    end
  end
`else
  logic [1:0] ptr_q, ptr_d, nxt_ptr;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
    .req   (req),
    .ptr   (ptr_q),
    .grant (grant)
  );
`endif

  always_comb begin
    g_sel = '0;
    g_a   = '0;
    g_b   = '0;
`ifndef ALU_ARB_FIXED_PRIO_EN
    nxt_ptr = '0;
`endif
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        g_sel = req_select[4*i +: 4];
        g_a   = req_a[8*i +: 8];
        g_b   = req_b[8*i +: 8];
`ifndef ALU_ARB_FIXED_PRIO_EN
        nxt_ptr = 2'((i + 1) % NUM_REQ);
`endif
      end
    end
  end

  // ack is the only combinational output: it must land in the IDLE cycle that takes the request.
  assign ack = (state_q == IDLE && !reset) ? grant : '0;

  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    done_d    = '0;
    err_d     = 1'b0;
    result_d  = result_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_sel_d = alu_sel_q;
    alu_do_d  = 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
    ptr_d     = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (|req) begin
          win_d = grant;
`ifndef ALU_ARB_FIXED_PRIO_EN
          ptr_d = nxt_ptr;
`endif
          // Rejected opcodes leave the ALU drive untouched and answer straight from RESP.
          if (op_no_result(g_sel)) begin
            state_d  = RESP;
            done_d   = grant;
            err_d    = 1'b1;
            result_d = '0;
          end else begin
            state_d   = ISSUE;
            alu_a_d   = g_a;
            alu_b_d   = g_b;
            alu_sel_d = g_sel;
            alu_do_d  = 1'b1;
          end
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        state_d  = RESP;
        result_d = alu_y;
        done_d   = win_q;
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      win_q     <= '0;
      done_q    <= '0;
      err_q     <= 1'b0;
      result_q  <= '0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_sel_q <= '0;
      alu_do_q  <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      ptr_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      done_q    <= done_d;
      err_q     <= err_d;
      result_q  <= result_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_sel_q <= alu_sel_d;
      alu_do_q  <= alu_do_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
      ptr_q     <= ptr_d;
`endif
    end
  end

  assign done       = done_q;
  assign err        = err_q;
  assign result     = result_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_select = alu_sel_q;
  assign alu_do     = alu_do_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with four requesters and a
// behavioural registered ALU.
module tb_alu_arbiter;

  localparam int unsigned N = 4;
`ifdef ALU_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req = '0;
  logic [4*N-1:0] req_select = '0;
  logic [8*N-1:0] req_a = '0;
  logic [8*N-1:0] req_b = '0;
  logic [N-1:0]   ack, done;
  logic           err, alu_do, busy;
  logic [7:0]     result, alu_a, alu_b;
  logic [7:0]     alu_y = '0;
  logic [3:0]     alu_select;

  int tests = 0;
  int fails = 0;
  int do_cnt = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.NUM_REQ(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .req_select (req_select),
    .req_a      (req_a),
    .req_b      (req_b),
    .ack        (ack),
    .done       (done),
    .err        (err),
    .result     (result),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_select (alu_select),
    .alu_do     (alu_do),
    .alu_y      (alu_y),
    .busy       (busy)
  );

  // Behavioural ALU: Y registered on the edge that samples alu_do.
  always @(posedge clk) begin
    if (alu_do) begin
      do_cnt <= do_cnt + 1;
      case (alu_select)
        4'h0:       alu_y <= alu_a + alu_b;
        4'h2, 4'hB: alu_y <= alu_a - alu_b;
        4'h6:       alu_y <= alu_a ^ alu_b;
        4'h8:       alu_y <= alu_a << 1;
        default:    alu_y <= 8'h00;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int i, input logic [3:0] s, input logic [7:0] a, input logic [7:0] b);
    req_select[4*i +: 4] = s;
    req_a[8*i +: 8]      = a;
    req_b[8*i +: 8]      = b;
    req[i]               = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    tests++;
    if ({ack, done, err, result} !== '0) begin
      fails++; $display("FAIL reset_status: got %h expected 0", {ack, done, err, result});
    end
    tests++;
    if ({alu_a, alu_b, alu_select, alu_do} !== '0) begin
      fails++; $display("FAIL reset_alu: got %h expected 0", {alu_a, alu_b, alu_select, alu_do});
    end
    reset = 1'b0;
    #1;
    tests++;
    if (busy !== 1'b0) begin
      fails++; $display("FAIL reset_busy: got %b expected 0", busy);
    end
  endtask

  task automatic test_single();
    tick();
    load(0, 4'h0, 8'h12, 8'h34);
    #1;
    tests++;
    if (ack !== 4'b0001) begin fails++; $display("FAIL single_ack: got %b expected 0001", ack); end
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL single_idle_busy: got %b expected 0", busy); end
    tick();
    req[0] = 1'b0;
    #1;
    tests++;
    if ({alu_do, alu_select, alu_a, alu_b} !== {1'b1, 4'h0, 8'h12, 8'h34}) begin
      fails++; $display("FAIL single_issue: got %h expected %h", {alu_do, alu_select, alu_a, alu_b}, {1'b1, 4'h0, 8'h12, 8'h34});
    end
    tests++;
    if ({ack, busy} !== 5'b0000_1) begin fails++; $display("FAIL single_issue_ack_busy: got %b expected 00001", {ack, busy}); end
    tick();
    tests++;
    if ({alu_do, done} !== 5'b0) begin fails++; $display("FAIL single_wait: got %b expected 00000", {alu_do, done}); end
    tick();
    tests++;
    if ({done, err, result} !== {4'b0001, 1'b0, 8'h46}) begin
      fails++; $display("FAIL single_done: got %h expected %h", {done, err, result}, {4'b0001, 1'b0, 8'h46});
    end
    tick();
    tests++;
    if ({done, busy, result} !== {4'b0000, 1'b0, 8'h46}) begin
      fails++; $display("FAIL single_hold: got %h expected %h", {done, busy, result}, {4'b0000, 1'b0, 8'h46});
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp2, exp3;
    logic [7:0] res2, res3;
    exp2 = FIXED ? 4'b0001 : 4'b0010;
    exp3 = FIXED ? 4'b0010 : 4'b0001;
    res2 = FIXED ? 8'h02 : 8'hFF;
    res3 = FIXED ? 8'hFF : 8'h02;
    tick();
    do_reset();
    load(0, 4'h2, 8'h05, 8'h07);
    load(1, 4'h6, 8'hF0, 8'h0F);
    #1;
    tests++;
    if (ack !== 4'b0001) begin fails++; $display("FAIL rr_ack1: got %b expected 0001", ack); end
    tick();
    req[0] = 1'b0;
    tick();
    tick();
    tests++;
    if ({done, result} !== {4'b0001, 8'hFE}) begin
      fails++; $display("FAIL rr_done1: got %h expected %h", {done, result}, {4'b0001, 8'hFE});
    end
    tick();
    load(0, 4'h0, 8'h01, 8'h01);
    #1;
    tests++;
    if (ack !== exp2) begin fails++; $display("FAIL rr_ack2: got %b expected %b", ack, exp2); end
    tick();
    req = req & ~exp2;
    tick();
    tick();
    tests++;
    if ({done, result} !== {exp2, res2}) begin
      fails++; $display("FAIL rr_done2: got %h expected %h", {done, result}, {exp2, res2});
    end
    tick();
    #1;
    tests++;
    if (ack !== exp3) begin fails++; $display("FAIL rr_ack3: got %b expected %b", ack, exp3); end
    tick();
    req = req & ~exp3;
    tick();
    tick();
    tests++;
    if ({done, result} !== {exp3, res3}) begin
      fails++; $display("FAIL rr_done3: got %h expected %h", {done, result}, {exp3, res3});
    end
  endtask

  task automatic test_reject();
    int c0;
    tick();
    c0 = do_cnt;
    load(1, 4'hE, 8'h55, 8'h66);
    #1;
    tests++;
    if (ack !== 4'b0010) begin fails++; $display("FAIL reject_ack: got %b expected 0010", ack); end
    tick();
    req[1] = 1'b0;
    #1;
    tests++;
    if ({done, err, result, alu_do} !== {4'b0010, 1'b1, 8'h00, 1'b0}) begin
      fails++; $display("FAIL reject_done: got %h expected %h", {done, err, result, alu_do}, {4'b0010, 1'b1, 8'h00, 1'b0});
    end
    tick();
    tests++;
    if ({done, err, busy} !== 6'b0) begin fails++; $display("FAIL reject_after: got %b expected 000000", {done, err, busy}); end
    tests++;
    if (do_cnt !== c0) begin fails++; $display("FAIL reject_no_alu_do: got %0d expected %0d", do_cnt, c0); end
  endtask

  task automatic test_reset_mid();
    tick();
    load(0, 4'hB, 8'hAA, 8'hAA);
    #1;
    tests++;
    if (ack !== 4'b0001) begin fails++; $display("FAIL rst_mid_ack: got %b expected 0001", ack); end
    tick();
    req[0] = 1'b0;
    #1;
    tests++;
    if ({alu_do, alu_a} !== {1'b1, 8'hAA}) begin
      fails++; $display("FAIL rst_mid_issue: got %h expected %h", {alu_do, alu_a}, {1'b1, 8'hAA});
    end
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    tests++;
    if ({ack, done, err, result, alu_a, alu_b, alu_select, alu_do, busy} !== '0) begin
      fails++; $display("FAIL rst_mid_outputs: got %h expected 0", {ack, done, err, result, alu_a, alu_b, alu_select, alu_do, busy});
    end
    load(0, 4'h0, 8'h03, 8'h04);
    load(1, 4'h0, 8'h10, 8'h20);
    #1;
    tests++;
    if (ack !== 4'b0001) begin fails++; $display("FAIL rst_mid_ptr: got %b expected 0001", ack); end
    tick();
    req[0] = 1'b0;
    tick();
    tick();
    tests++;
    if ({done, result} !== {4'b0001, 8'h07}) begin
      fails++; $display("FAIL rst_mid_done: got %h expected %h", {done, result}, {4'b0001, 8'h07});
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_ack;
    logic [3:0] seen;
    seen = '0;
    tick();
    do_reset();
    for (int k = 0; k < 4; k++) load(k, 4'h8, 8'h81, 8'h00);
    for (int c = 0; c < 16; c++) begin
      if (c > 0) begin
        tick();
        req = req & ~seen;
      end
      #1;
      exp_ack = (c % 4 == 0) ? 4'(1 << (c / 4)) : 4'b0000;
      tests++;
      if (ack !== exp_ack) begin fails++; $display("FAIL b2b_ack[%0d]: got %b expected %b", c, ack, exp_ack); end
      tests++;
      if (busy !== (c % 4 != 0)) begin fails++; $display("FAIL b2b_busy[%0d]: got %b expected %b", c, busy, (c % 4 != 0)); end
      if (c % 4 == 3) begin
        tests++;
        if ({done, result} !== {4'(1 << (c / 4)), 8'h02}) begin
          fails++; $display("FAIL b2b_done[%0d]: got %h expected %h", c, {done, result}, {4'(1 << (c / 4)), 8'h02});
        end
      end
      seen = ack;
    end
    tick();
    req = req & ~seen;
    #1;
    tests++;
    if ({ack, busy, done} !== 9'b0) begin fails++; $display("FAIL b2b_end: got %b expected 0", {ack, busy, done}); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_reject();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
